pupil_detect_stream: RTL and testbench
======================================

Name: pupil_detect_stream

Overview:
- Streaming, parametrised successor to the frame-buffer pupil detector.
- Consumes the inward camera's grayscale pixel stream one pixel per accepted beat; no full line buffer is needed.
- Per line, finds the widest dark run: it opens on a falling edge greater than the threshold and closes on a rising edge greater than the threshold.
- Scans the whole frame rather than stopping when the blob shrinks, and reports the centre of the widest run with a one-cycle valid pulse at end of frame.

Parameters:
- IMG_WIDTH, 112, pixels per line.
- IMG_HEIGHT, 112, lines per frame.
- PIX_W, 8, grayscale bits per pixel (0 = black).
- COORD_W, 8, coordinate width; must satisfy 2^COORD_W > max(IMG_WIDTH, IMG_HEIGHT).
- DEF_THRESHOLD, 80, threshold loaded at reset.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- threshold  in  PIX_W  edge threshold; sampled on an accepted pix_sof beat.
- pix_valid  in  1  pixel beat valid.
- pix_data  in  PIX_W  pixel value.
- pix_sof  in  1  first pixel of frame; qualified by pix_valid.
- pix_eol  in  1  last pixel of line; qualified by pix_valid.
- pupil_x  out  COORD_W  horizontal centre of the widest run.
- pupil_y  out  COORD_W  line index of the widest run.
- pupil_found  out  1  a run was found in the last completed frame.
- pupil_valid  out  1  one-cycle result strobe.
- busy  out  1  frame scan in progress.

Behaviour:
- Reset values:
  - pupil_x and pupil_y reset to all-ones.
  - pupil_found, pupil_valid and busy reset to 0.
  - Internal threshold resets to DEF_THRESHOLD.
  - All counters and best-run registers reset to 0; FSM resets to IDLE.
- Frame FSM:
  - IDLE -> SCAN on pix_valid && pix_sof. This also clears line=0, col=0 and best_len=0, and latches threshold.
  - SCAN -> DONE on pix_valid && pix_eol && line==IMG_HEIGHT-1.
  - DONE -> IDLE unconditionally; pupil_valid=1 for this single cycle.
  - busy=1 in SCAN only.
- Line FSM (runs only in SCAN): SEEK_BEGIN / SEEK_END.
  - Comparisons use PIX_W+1-bit signed differences; no unsigned wrap.
  - The first pixel of each line (col==0) is loaded as prev only; no compare.
  - SEEK_BEGIN: if prev - cur > thr, set run_begin=col and go to SEEK_END.
  - SEEK_END: if cur - prev > thr, set run_len=col-run_begin and go back to SEEK_BEGIN. This closes the run and compares it against the line's best.
  - Closed runs with run_len greater than line_best_len replace the line best. Equal length keeps the earlier run.
  - A run still open at eol is discarded.
  - Both edges are evaluated on the eol pixel itself before the line closes.
- End of line (accepted pix_eol):
  - If line_best_len > best_len (strict), update best_len, best_begin, and best_line=line.
  - Ties keep the earliest line.
  - Then reset col and the line FSM; line increments.
- Columns:
  - col saturates at IMG_WIDTH-1.
  - Pixels beyond that before eol are ignored for compares.
  - An eol arriving early ends the line normally.
- DONE cycle:
  - If best_len>0: pupil_found=1, pupil_y=best_line, pupil_x=best_begin+((best_len-1)>>1), computed at COORD_W+1 bits and truncated.
  - Otherwise pupil_found=0 and pupil_x/pupil_y hold their previous values.
- Latency: pupil_valid is asserted on the cycle after the final eol beat is accepted.
- Boundary conditions:
  - pix_valid=0 beats are stalls: no state change.
  - pix_sof during SCAN aborts the current frame without a pupil_valid pulse, then restarts with that beat as pixel 0 of line 0.
  - pix_sof and pix_eol on the same beat are legal (a one-pixel line). With IMG_HEIGHT==1 this ends the frame.
  - Beats in IDLE without pix_sof are ignored.
  - Asserting reset mid-frame returns all registers to their reset values immediately; outputs reset with no pulse.

Optional Feature:
- Macro: PUPIL_DETECT_VCENTER_EN.
- Enabled:
  - Tracks first_line and last_line, i.e. the lines whose line_best_len ≥ best_len/2 that are contiguous with best_line.
  - pupil_y = (first_line+last_line)>>1.
  - Adds outputs pupil_top and pupil_bottom (COORD_W each), reset to all-ones.
- Disabled: pupil_y = best_line; no extra ports or logic.

Decomposition:
- Package pupil_pkg holds:
  - frame state encoding (IDLE/SCAN/DONE);
  - line state encoding (SEEK_BEGIN/SEEK_END);
  - DEF_ constants (112, 80);
  - coordinate width check.
- One sub-module, pupil_line_scan, is natural. It holds the per-line edge detector and widest-run tracker. Outputs: line_best_len, line_best_begin, line_done. Frame-level best tracking and the FSM stay in the top.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=4, threshold=80):
- Uniform frame of 200s -> pupil_valid pulses once, 1 cycle after final eol; pupil_found=0; pupil_x/pupil_y stay 0xFF.
- Line 2 = 200,200,10,10,10,200,200,200, other lines all 200 -> pupil_found=1, pupil_x=3, pupil_y=2.
- Line 1 run of length 3 at cols 1-3 and line 3 run of length 3 at cols 4-6 (tie) -> pupil_y=1, pupil_x=2.
- Line run opens at col 5 and never closes before eol -> run discarded; pupil_found=0.
- Edge of exactly 80 (200->120) -> no run. Edge of 81 (201->120) -> run opens.
- Random pix_valid stalls with the second test's data -> identical result. A pix_sof injected on line 2 -> no pulse for the aborted frame; the restarted frame reports correctly. Reset mid-scan -> outputs at reset values, busy=0.

Source files
------------

// File: rtl/pupil_pkg.sv
// rtl/pupil_pkg.sv - shared encodings, defaults and size check for the streaming pupil detector
package pupil_pkg;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_SCAN,
    FR_DONE
  } frame_state_t;

  typedef enum logic {
    SEEK_BEGIN,
    SEEK_END
  } line_state_t;

  localparam int DEF_IMG_SIZE  = 112;
  localparam int DEF_THR_LEVEL = 80;

  // Every column and line index, plus the one-past-last line count, must fit in COORD_W.
  function automatic bit coord_fits(input int coord_w, input int width, input int height);
    longint dim;
    dim = (width > height) ? longint'(width) : longint'(height);
    return (longint'(1) << coord_w) > dim;
  endfunction

endpackage

// File: rtl/pupil_line_scan.sv
// rtl/pupil_line_scan.sv - per-line dark-run edge detector and widest-run tracker
module pupil_line_scan
  import pupil_pkg::*;
#(
  parameter int IMG_WIDTH = DEF_IMG_SIZE,
  parameter int PIX_W     = 8,
  parameter int COORD_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               beat,
  input  logic [PIX_W-1:0]   pix_data,
  input  logic               pix_eol,
  input  logic [PIX_W-1:0]   thr,
  output logic [COORD_W-1:0] line_best_len,
  output logic [COORD_W-1:0] line_best_begin,
  output logic               line_done
);

  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

  logic [COORD_W-1:0] col, run_begin, best_len_q, best_begin_q;
  logic [PIX_W-1:0]   prev;
  logic               past_end;
  line_state_t        lstate;

  logic [COORD_W-1:0] e_col, e_len, e_begin, run_len, n_len, n_begin;
  logic               e_past, compare, opens, closes;
  line_state_t        e_state;
  logic signed [PIX_W:0] fall, rise, thr_s;

  // A start beat is pixel 0 of a fresh line, so it sees cleared state regardless of the registers.
  always_comb begin
    e_col   = start ? '0 : col;
    e_state = start ? SEEK_BEGIN : lstate;
    e_past  = start ? 1'b0 : past_end;
    e_len   = start ? '0 : best_len_q;
    e_begin = start ? '0 : best_begin_q;
    fall    = {1'b0, prev} - {1'b0, pix_data};
    rise    = {1'b0, pix_data} - {1'b0, prev};
    thr_s   = {1'b0, thr};
    compare = beat && !e_past && (e_col != '0);
    opens   = compare && (e_state == SEEK_BEGIN) && (fall > thr_s);
    closes  = compare && (e_state == SEEK_END) && (rise > thr_s);
    run_len = e_col - run_begin;
    n_len   = e_len;
    n_begin = e_begin;
    if (closes && (run_len > e_len)) begin
      n_len   = run_len;
      n_begin = run_begin;
    end
  end

  assign line_best_len   = n_len;
  assign line_best_begin = n_begin;
  assign line_done       = beat && pix_eol;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col          <= '0;
      run_begin    <= '0;
      best_len_q   <= '0;
      best_begin_q <= '0;
      prev         <= '0;
      past_end     <= 1'b0;
      lstate       <= SEEK_BEGIN;
    end else if (beat) begin
      if (pix_eol) begin
        col          <= '0;
        best_len_q   <= '0;
        best_begin_q <= '0;
        past_end     <= 1'b0;
        lstate       <= SEEK_BEGIN;
      end else begin
        if (!e_past) prev <= pix_data;
        col          <= (e_col == LAST_COL) ? e_col : e_col + ONE;
        past_end     <= e_past || (e_col == LAST_COL);
        best_len_q   <= n_len;
        best_begin_q <= n_begin;
        if (opens) begin
          lstate    <= SEEK_END;
          run_begin <= e_col;
        end else if (closes) begin
          lstate <= SEEK_BEGIN;
        end else begin
          lstate <= e_state;
        end
      end
    end
  end

endmodule

// File: rtl/pupil_detect_stream.sv
// rtl/pupil_detect_stream.sv - streaming pupil detector: frame FSM and frame-level widest-run tracking
// Optional vertical centring of pupil_y over neighbouring lines: PUPIL_DETECT_VCENTER_EN.
module pupil_detect_stream
  import pupil_pkg::*;
#(
  parameter int               IMG_WIDTH     = DEF_IMG_SIZE,
  parameter int               IMG_HEIGHT    = DEF_IMG_SIZE,
  parameter int               PIX_W         = 8,
  parameter int               COORD_W       = 8,
  parameter logic [PIX_W-1:0] DEF_THRESHOLD = PIX_W'(DEF_THR_LEVEL)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PIX_W-1:0]   threshold,
  input  logic               pix_valid,
  input  logic [PIX_W-1:0]   pix_data,
  input  logic               pix_sof,
  input  logic               pix_eol,
  output logic [COORD_W-1:0] pupil_x,
  output logic [COORD_W-1:0] pupil_y,
  output logic               pupil_found,
  output logic               pupil_valid,
  output logic               busy
`ifdef PUPIL_DETECT_VCENTER_EN
  ,
  output logic [COORD_W-1:0] pupil_top,
  output logic [COORD_W-1:0] pupil_bottom
`endif
);

  if (!coord_fits(COORD_W, IMG_WIDTH, IMG_HEIGHT)) begin : g_coord_check
    $error("COORD_W too narrow for IMG_WIDTH/IMG_HEIGHT");
  end

  localparam logic [COORD_W-1:0] LAST_LINE = COORD_W'(IMG_HEIGHT - 1);
  localparam logic [COORD_W-1:0] ONE       = COORD_W'(1);

  frame_state_t       state;
  logic [PIX_W-1:0]   thr_q;
  logic [COORD_W-1:0] line, best_len, best_begin, best_line;
  logic [COORD_W-1:0] line_best_len, line_best_begin;
  logic               line_done, start, scan_beat;

  logic [COORD_W-1:0] f_line, f_best_len, f_best_begin, f_best_line;
  logic [COORD_W-1:0] n_best_len, n_best_begin, n_best_line, centre;
  logic               take, frame_end;

  // A sof beat in IDLE or mid-scan starts a new frame; DONE always falls straight back to IDLE.
  assign start     = pix_valid && pix_sof && (state != FR_DONE);
  assign scan_beat = pix_valid && ((state == FR_SCAN) || start);

  pupil_line_scan #(
    .IMG_WIDTH(IMG_WIDTH),
    .PIX_W    (PIX_W),
    .COORD_W  (COORD_W)
  ) u_line_scan (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .beat           (scan_beat),
    .pix_data       (pix_data),
    .pix_eol        (pix_eol),
    .thr            (thr_q),
    .line_best_len  (line_best_len),
    .line_best_begin(line_best_begin),
    .line_done      (line_done)
  );

  always_comb begin
    f_line       = start ? '0 : line;
    f_best_len   = start ? '0 : best_len;
    f_best_begin = start ? '0 : best_begin;
    f_best_line  = start ? '0 : best_line;
    take         = line_done && (line_best_len > f_best_len);
    n_best_len   = take ? line_best_len : f_best_len;
    n_best_begin = take ? line_best_begin : f_best_begin;
    n_best_line  = take ? f_line : f_best_line;
    frame_end    = line_done && (f_line == LAST_LINE);
    centre       = COORD_W'({1'b0, n_best_begin} + (({1'b0, n_best_len} - 1'b1) >> 1));
  end

`ifdef PUPIL_DETECT_VCENTER_EN
  logic [COORD_W-1:0] first_line, last_line, streak_first;
  logic               streak_on, track_on;
  logic [COORD_W-1:0] f_first, f_last, f_streak_first, n_first, n_last, n_streak_first;
  logic [COORD_W-1:0] y_centre;
  logic               f_streak_on, f_track_on, n_streak_on, n_track_on, qual;

  // Lines at least half as wide as the best, touching the best line, extend the vertical span.
  always_comb begin
    f_first        = start ? '0 : first_line;
    f_last         = start ? '0 : last_line;
    f_streak_first = start ? '0 : streak_first;
    f_streak_on    = start ? 1'b0 : streak_on;
    f_track_on     = start ? 1'b0 : track_on;
    qual           = {line_best_len, 1'b0} >= {1'b0, n_best_len};
    n_first        = f_first;
    n_last         = f_last;
    n_streak_first = f_streak_first;
    n_streak_on    = f_streak_on;
    n_track_on     = f_track_on;
    if (line_done) begin
      if (take) begin
        n_first    = f_streak_on ? f_streak_first : f_line;
        n_last     = f_line;
        n_track_on = 1'b1;
      end else if (qual && f_track_on) begin
        n_last = f_line;
      end else if (!qual) begin
        n_track_on = 1'b0;
      end
      n_streak_on    = qual;
      n_streak_first = (qual && f_streak_on) ? f_streak_first : f_line;
    end
    y_centre = COORD_W'(({1'b0, n_first} + {1'b0, n_last}) >> 1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      first_line   <= '0;
      last_line    <= '0;
      streak_first <= '0;
      streak_on    <= 1'b0;
      track_on     <= 1'b0;
      pupil_top    <= '1;
      pupil_bottom <= '1;
    end else if ((state != FR_DONE) && scan_beat) begin
      first_line   <= n_first;
      last_line    <= n_last;
      streak_first <= n_streak_first;
      streak_on    <= n_streak_on;
      track_on     <= n_track_on;
      if (frame_end && (n_best_len != '0)) begin
        pupil_top    <= n_first;
        pupil_bottom <= n_last;
      end
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= FR_IDLE;
      thr_q       <= DEF_THRESHOLD;
      line        <= '0;
      best_len    <= '0;
      best_begin  <= '0;
      best_line   <= '0;
      pupil_x     <= '1;
      pupil_y     <= '1;
      pupil_found <= 1'b0;
      pupil_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      pupil_valid <= 1'b0;
      if (state == FR_DONE) begin
        state <= FR_IDLE;
      end else if (scan_beat) begin
        if (start) thr_q <= threshold;
        line       <= line_done ? f_line + ONE : f_line;
        best_len   <= n_best_len;
        best_begin <= n_best_begin;
        best_line  <= n_best_line;
        if (frame_end) begin
          state       <= FR_DONE;
          busy        <= 1'b0;
          pupil_valid <= 1'b1;
          pupil_found <= (n_best_len != '0);
          if (n_best_len != '0) begin
            pupil_x <= centre;
`ifdef PUPIL_DETECT_VCENTER_EN
            pupil_y <= y_centre;
`else
            pupil_y <= n_best_line;
`endif
          end
        end else begin
          state <= FR_SCAN;
          busy  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pupil_detect_stream.sv
// tb/tb_pupil_detect_stream.sv - directed and randomised bench for pupil_detect_stream (8x4 frames)
module tb_pupil_detect_stream;

  localparam int W = 8;
  localparam int H = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] threshold, pix_data, pupil_x, pupil_y;
  logic       pix_valid, pix_sof, pix_eol, pupil_found, pupil_valid, busy;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int pix[H][12];
  int llen[H];
  int exp_x = 255;
  int exp_y = 255;

  pupil_detect_stream #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .PIX_W     (8),
    .COORD_W   (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .threshold  (threshold),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .pupil_x    (pupil_x),
    .pupil_y    (pupil_y),
    .pupil_found(pupil_found),
    .pupil_valid(pupil_valid),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (pupil_valid === 1'b1) pulses++;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, bad=%0d", bad);
    $fatal(1);
  end

  task automatic beat(input int d, input bit sof, input bit eol, input int stall_pct);
    while (int'($urandom_range(99, 0)) < stall_pct) begin
      pix_valid = 1'b0;
      pix_data  = 8'($urandom);
      pix_sof   = 1'($urandom);
      pix_eol   = 1'($urandom);
      @(negedge clock);
    end
    pix_valid = 1'b1;
    pix_data  = 8'(d);
    pix_sof   = sof;
    pix_eol   = eol;
    @(negedge clock);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
  endtask

  task automatic send_lines(input int first, input int last, input int stall_pct);
    for (int l = first; l <= last; l++)
      for (int c = 0; c < llen[l]; c++)
        beat(pix[l][c], (l == 0) && (c == 0), c == llen[l] - 1, stall_pct);
  endtask

  task automatic fill(input int v);
    for (int l = 0; l < H; l++) begin
      llen[l] = W;
      for (int c = 0; c < 12; c++) pix[l][c] = v;
    end
  endtask

  task automatic set_line(input int l, input int v[W]);
    for (int c = 0; c < W; c++) pix[l][c] = v[c];
  endtask

  // Reference: scan each line left to right, opening on a steep fall and closing on a steep rise.
  function automatic void model(input int thr, output bit f, output int x, output int y);
    int blen, bbeg, bline, lb, lbeg, rb, n, d;
    bit open;
    blen = 0; bbeg = 0; bline = 0;
    for (int l = 0; l < H; l++) begin
      lb = 0; lbeg = 0; rb = 0; open = 0;
      n = (llen[l] < W) ? llen[l] : W;
      for (int c = 1; c < n; c++) begin
        d = pix[l][c-1] - pix[l][c];
        if (!open && d > thr) begin
          open = 1; rb = c;
        end else if (open && -d > thr) begin
          open = 0;
          if (c - rb > lb) begin lb = c - rb; lbeg = rb; end
        end
      end
      if (lb > blen) begin blen = lb; bbeg = lbeg; bline = l; end
    end
    f = blen > 0;
    x = bbeg + (blen - 1) / 2;
    y = bline;
  endfunction

  task automatic test_reset();
    total++;
    if (pupil_x !== 8'hFF || pupil_y !== 8'hFF || pupil_found !== 1'b0 || pupil_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got x=%0d y=%0d f=%b v=%b, want x=255 y=255 f=0 v=0", pupil_x, pupil_y, pupil_found, pupil_valid);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_uniform();
    fill(200);
    send_lines(0, H - 2, 0);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL uniform_busy: got %b want 1", busy); end
    send_lines(H - 1, H - 1, 0);
    total++;
    if (pupil_valid !== 1'b1 || pupil_found !== 1'b0 || pupil_x !== 8'hFF || pupil_y !== 8'hFF || busy !== 1'b0) begin
      bad++;
      $display("FAIL uniform: got v=%b f=%b x=%0d y=%0d busy=%b, want v=1 f=0 x=255 y=255 busy=0", pupil_valid, pupil_found, pupil_x, pupil_y, busy);
    end
    @(negedge clock);
    total++;
    if (pupil_valid !== 1'b0) begin bad++; $display("FAIL uniform_pulse_width: got v=%b want 0", pupil_valid); end
  endtask

  task automatic test_center();
    fill(200);
    set_line(2, '{200, 200, 10, 10, 10, 200, 200, 200});
    send_lines(0, H - 1, 0);
    total++;
    if (pupil_valid !== 1'b1 || pupil_found !== 1'b1 || pupil_x !== 8'd3 || pupil_y !== 8'd2) begin
      bad++;
      $display("FAIL center: got v=%b f=%b x=%0d y=%0d, want v=1 f=1 x=3 y=2", pupil_valid, pupil_found, pupil_x, pupil_y);
    end
    @(negedge clock);
    total++;
    if (pupil_valid !== 1'b0) begin bad++; $display("FAIL center_pulse_width: got v=%b want 0", pupil_valid); end
  endtask

  task automatic load_tie();
    fill(200);
    set_line(1, '{200, 10, 10, 10, 200, 200, 200, 200});
    set_line(3, '{200, 200, 200, 200, 10, 10, 10, 200});
  endtask

  task automatic test_tie();
    load_tie();
    send_lines(0, H - 1, 0);
    total++;
    if (pupil_valid !== 1'b1 || pupil_found !== 1'b1 || pupil_x !== 8'd2 || pupil_y !== 8'd1) begin
      bad++;
      $display("FAIL tie: got v=%b f=%b x=%0d y=%0d, want v=1 f=1 x=2 y=1", pupil_valid, pupil_found, pupil_x, pupil_y);
    end
    @(negedge clock);
  endtask

  task automatic test_open_run();
    fill(200);
    set_line(2, '{200, 200, 200, 200, 200, 10, 10, 10});
    send_lines(0, H - 1, 0);
    total++;
    if (pupil_valid !== 1'b1 || pupil_found !== 1'b0 || pupil_x !== 8'd2 || pupil_y !== 8'd1) begin
      bad++;
      $display("FAIL open_run: got v=%b f=%b x=%0d y=%0d, want v=1 f=0 x=2 y=1 (held)", pupil_valid, pupil_found, pupil_x, pupil_y);
    end
    @(negedge clock);
  endtask

  task automatic test_threshold();
    fill(200);
    set_line(0, '{200, 120, 120, 200, 200, 200, 200, 200});
    send_lines(0, H - 1, 0);
    total++;
    if (pupil_valid !== 1'b1 || pupil_found !== 1'b0) begin
      bad++;
      $display("FAIL thr_equal: got v=%b f=%b, want v=1 f=0", pupil_valid, pupil_found);
    end
    @(negedge clock);
    set_line(0, '{201, 120, 120, 201, 201, 201, 201, 201});
    send_lines(0, H - 1, 0);
    total++;
    if (pupil_valid !== 1'b1 || pupil_found !== 1'b1 || pupil_x !== 8'd1 || pupil_y !== 8'd0) begin
      bad++;
      $display("FAIL thr_above: got v=%b f=%b x=%0d y=%0d, want v=1 f=1 x=1 y=0", pupil_valid, pupil_found, pupil_x, pupil_y);
    end
    @(negedge clock);
  endtask

  task automatic test_stalls();
    int p0;
    fill(200);
    set_line(2, '{200, 200, 10, 10, 10, 200, 200, 200});
    p0 = pulses;
    send_lines(0, H - 1, 40);
    total++;
    if (pupil_valid !== 1'b1 || pupil_found !== 1'b1 || pupil_x !== 8'd3 || pupil_y !== 8'd2) begin
      bad++;
      $display("FAIL stalls: got v=%b f=%b x=%0d y=%0d, want v=1 f=1 x=3 y=2", pupil_valid, pupil_found, pupil_x, pupil_y);
    end
    repeat (3) @(negedge clock);
    #1;
    total++;
    if (pulses !== p0 + 1) begin bad++; $display("FAIL stalls_pulses: got %0d want %0d", pulses - p0, 1); end
  endtask

  task automatic test_abort();
    int p0;
    fill(200);
    set_line(0, '{200, 10, 10, 10, 10, 10, 10, 200});
    p0 = pulses;
    send_lines(0, 1, 0);
    for (int c = 0; c < 3; c++) beat(pix[2][c], 1'b0, 1'b0, 0);
    load_tie();
    send_lines(0, H - 1, 0);
    total++;
    if (pupil_valid !== 1'b1 || pupil_found !== 1'b1 || pupil_x !== 8'd2 || pupil_y !== 8'd1) begin
      bad++;
      $display("FAIL abort_restart: got v=%b f=%b x=%0d y=%0d, want v=1 f=1 x=2 y=1", pupil_valid, pupil_found, pupil_x, pupil_y);
    end
    repeat (2) @(negedge clock);
    #1;
    total++;
    if (pulses !== p0 + 1) begin bad++; $display("FAIL abort_pulses: got %0d want %0d", pulses - p0, 1); end
  endtask

  task automatic test_reset_mid();
    int p0;
    fill(200);
    set_line(1, '{200, 10, 10, 10, 200, 200, 200, 200});
    send_lines(0, 1, 0);
    p0 = pulses;
    reset = 1'b1;
    #1;
    total++;
    if (pupil_x !== 8'hFF || pupil_y !== 8'hFF || pupil_found !== 1'b0 || pupil_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got x=%0d y=%0d f=%b v=%b busy=%b, want 255 255 0 0 0", pupil_x, pupil_y, pupil_found, pupil_valid, busy);
    end
    @(negedge clock);
    reset = 1'b0;
    exp_x = 255;
    exp_y = 255;
    for (int c = 0; c < W; c++) beat(200, 1'b0, c == W - 1, 0);
    repeat (2) @(negedge clock);
    #1;
    total++;
    if (pulses !== p0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_idle: got pulses=%0d busy=%b, want pulses=0 busy=0", pulses - p0, busy);
    end
  endtask

  task automatic test_random();
    bit f;
    int x, y, thr;
    for (int k = 0; k < 10; k++) begin
      for (int l = 0; l < H; l++) begin
        llen[l] = ($urandom_range(1, 0) == 0) ? W : int'($urandom_range(11, 1));
        for (int c = 0; c < 12; c++)
          pix[l][c] = ($urandom_range(2, 0) == 0) ? int'($urandom_range(60, 0)) : int'($urandom_range(255, 140));
      end
      thr = int'($urandom_range(120, 60));
      threshold = 8'(thr);
      model(thr, f, x, y);
      if (f) begin exp_x = x; exp_y = y; end
      send_lines(0, H - 1, 25);
      threshold = 8'd80;
      total++;
      if (pupil_valid !== 1'b1 || pupil_found !== f || pupil_x !== 8'(exp_x) || pupil_y !== 8'(exp_y)) begin
        bad++;
        $display("FAIL random[%0d]: got v=%b f=%b x=%0d y=%0d, want v=1 f=%b x=%0d y=%0d", k, pupil_valid, pupil_found, pupil_x, pupil_y, f, exp_x, exp_y);
      end
      repeat (2) @(negedge clock);
    end
  endtask

  initial begin
    reset     = 1'b1;
    threshold = 8'd80;
    pix_valid = 1'b0;
    pix_data  = 8'd0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b0;
    @(negedge clock);
    test_uniform();
    test_center();
    test_tie();
    test_open_run();
    test_threshold();
    test_stalls();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
